mpu_load_store: RTL
===================

Name: mpu_load_store

Overview:
Parametrised matrix register file with independent load and store streaming channels. It is the next generation of the MPU LOAD/STORE path. Elements arrive and leave one per cycle in row-major order over valid/ready handshakes, replacing the fixed 3x3 parallel matrix bus. It sits between the MPU bus front end and the multiply datapath, and adds per-register dimension tracking, error reporting and a load/store hazard interlock.

Parameters:
FP, 32, element width in bits (SP=32; DP=64 legal)
M, 5, maximum rows per matrix
N, 5, maximum columns per matrix
MATRIX_REGISTERS, 16, number of matrix registers
RBITS, $clog2(MATRIX_REGISTERS), register address width (derived)
DBITS, $clog2(max(M,N)+1), dimension field width (derived)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ld_req  in  1  start load; sampled when ld_ready=1
ld_addr  in  RBITS  destination register
ld_m  in  DBITS  row count of incoming matrix
ld_n  in  DBITS  column count of incoming matrix
ld_ready  out  1  load FSM idle and able to accept ld_req
ld_valid  in  1  ld_data valid
ld_data  in  FP  element, row-major
ld_data_ready  out  1  element accepted when ld_valid & ld_data_ready
ld_done  out  1  one-cycle pulse after last element written
ld_error  out  1  one-cycle pulse, load request rejected
st_req  in  1  start store; sampled when st_ready=1
st_addr  in  RBITS  source register
st_ready  out  1  store FSM idle
st_valid  out  1  st_data valid
st_data  out  FP  element, row-major
st_data_ready  in  1  downstream accepts element
st_last  out  1  qualifies final element of matrix
st_m  out  DBITS  dimensions of matrix being stored, held for the whole transfer
st_n  out  DBITS  (same)
st_error  out  1  one-cycle pulse, store request rejected

Behaviour:
- Reset (async, reset_n=0): both FSMs go to IDLE; all dims cleared to 0. Outputs: ld_ready=1, st_ready=1, every other output 0. Element storage is not reset.
- Load FSM states: LOAD_IDLE and LOAD_MATRIX.
  - LOAD_IDLE: ld_data_ready=0. On ld_req, ld_m/ld_n are checked.
  - Illegal request (ld_m=0, ld_m>M, ld_n=0 or ld_n>N): ld_error pulses next cycle, state stays IDLE, nothing written.
  - Legal request: latch addr/m/n, clear row/col counters, go to LOAD_MATRIX.
- LOAD_MATRIX:
  - ld_data_ready=1, ld_ready=0.
  - Each handshake writes element [row][col] of register addr. col increments; when col wraps at n-1, row increments.
  - On the handshake of element (m-1,n-1): dims[addr] are updated, ld_done pulses the following cycle, state returns to LOAD_IDLE.
  - Unused positions beyond m x n keep stale contents.
- Store FSM states: STORE_IDLE and STORE_MATRIX.
  - On st_req with dims[st_addr]=0: st_error pulses next cycle, state stays IDLE.
  - Otherwise latch addr, drive st_m/st_n, go to STORE_MATRIX.
  - First st_valid is asserted the cycle after acceptance (latency 1). st_data is registered.
  - Each cycle with st_valid & st_data_ready advances the element. st_data and st_valid hold stable while st_data_ready=0.
  - st_last=1 with element (m-1,n-1); after its handshake, st_valid drops and state returns to STORE_IDLE.
- Hazard interlock:
  - While the load FSM is in LOAD_MATRIX, st_ready=0 if st_addr equals the latched load addr.
  - The load FSM holds ld_ready=0 while st_req targets the register currently being stored.
  - Loads and stores to different registers proceed concurrently at full rate.
- Load completion and a same-address st_req in the same cycle: the store is not accepted that cycle (interlock). Next cycle it is accepted and returns the new data.
- Reloading a register with different dims overwrites its dims. Stale elements are never emitted because store counts use the latched dims.
- Reset mid-transfer aborts immediately. The partially loaded register's dims stay 0 (cleared by reset).
- Throughput: 1 element/cycle per channel; a back-to-back request is accepted the cycle after returning to IDLE.

Decomposition:
- Extend mpu_pkg with:
  - load_state_t / store_state_t (reuse existing encodings);
  - typedef mpu_dims_t {m, n};
  - function dims_legal(m, n).
- Global sizes stay in global_defs (M, N, MATRIX_REGISTERS, FP).
- One sub-module is natural: mpu_elem_counter, the row/col counter with wrap and last-element flag, instantiated once per channel.

Test Plan:
- Load 3x3 of values 1.0..9.0 (0x3F800000..0x41100000) into reg 4, then store reg 4 with st_data_ready=1 -> 9 beats in row-major order, st_last on beat 9, st_m=st_n=3, ld_done one cycle after the 9th load handshake.
- Load 5x5 into reg 15, then 2x3 into reg 15; store reg 15 -> exactly 6 elements, the new values, st_m=2, st_n=3.
- ld_req with m=6, n=2 (and separately m=0) -> ld_error pulse, dims unchanged; st_req to never-loaded reg 7 -> st_error pulse, no st_valid.
- Store reg 1 with st_data_ready toggling 1,0,0,1 -> st_data held constant during stalls, no element skipped or duplicated.
- Load reg 2 in progress while st_req reg 2 -> st_ready=0 until load done, then stored data matches new load; concurrent store of reg 3 runs unstalled.
- Assert reset_n=0 mid-load after 4 elements -> outputs at reset values; afterwards st_req of that reg -> st_error.

Source files
------------

// File: rtl/mpu_load_store_pkg.sv
// Shared sizes, FSM state encodings and dimension helpers for the matrix load/store path.
package mpu_load_store_pkg;
  localparam int FP               = 32;
  localparam int M                = 5;
  localparam int N                = 5;
  localparam int MATRIX_REGISTERS = 16;
  localparam int RBITS            = $clog2(MATRIX_REGISTERS);
  localparam int MAXD             = (M > N) ? M : N;
  localparam int DBITS            = $clog2(MAXD + 1);

  typedef logic [DBITS-1:0] dim_t;
  typedef logic [RBITS-1:0] raddr_t;
  typedef logic [FP-1:0]    elem_t;

  localparam dim_t M_MAX = dim_t'(M);
  localparam dim_t N_MAX = dim_t'(N);

  typedef enum logic {LOAD_IDLE = 1'b0, LOAD_MATRIX = 1'b1} load_state_t;
  typedef enum logic {STORE_IDLE = 1'b0, STORE_MATRIX = 1'b1} store_state_t;

  typedef struct packed {
    dim_t m;
    dim_t n;
  } mpu_dims_t;

  function automatic logic dims_legal(dim_t m, dim_t n);
    return (m != '0) && (m <= M_MAX) && (n != '0) && (n <= N_MAX);
  endfunction
endpackage

// File: rtl/mpu_load_store_if.sv
// Load and store streaming channels between the bus front end and the matrix register file.
interface mpu_load_store_if;
  import mpu_load_store_pkg::*;

  logic   ld_req;
  raddr_t ld_addr;
  dim_t   ld_m;
  dim_t   ld_n;
  logic   ld_ready;
  logic   ld_valid;
  elem_t  ld_data;
  logic   ld_data_ready;
  logic   ld_done;
  logic   ld_error;

  logic   st_req;
  raddr_t st_addr;
  logic   st_ready;
  logic   st_valid;
  elem_t  st_data;
  logic   st_data_ready;
  logic   st_last;
  dim_t   st_m;
  dim_t   st_n;
  logic   st_error;

  modport slave (
    input  ld_req, ld_addr, ld_m, ld_n, ld_valid, ld_data,
    input  st_req, st_addr, st_data_ready,
    output ld_ready, ld_data_ready, ld_done, ld_error,
    output st_ready, st_valid, st_data, st_last, st_m, st_n, st_error
  );

  modport master (
    output ld_req, ld_addr, ld_m, ld_n, ld_valid, ld_data,
    output st_req, st_addr, st_data_ready,
    input  ld_ready, ld_data_ready, ld_done, ld_error,
    input  st_ready, st_valid, st_data, st_last, st_m, st_n, st_error
  );
endinterface

// File: rtl/mpu_load_store_elem_counter.sv
// Row-major row/col counter with wrap at n-1; advances on adv, restarts on clr.
// LOOKAHEAD=1 presents the position after the next advance so a registered read can prefetch it.
module mpu_load_store_elem_counter
  import mpu_load_store_pkg::*;
#(
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic adv,
  input  dim_t m,
  input  dim_t n,
  output dim_t row,
  output dim_t col,
  output logic last
);
  dim_t row_q, col_q, row_nxt, col_nxt;
  logic col_wrap;

  always_comb begin
    col_wrap = (col_q == n - dim_t'(1));
    row_nxt  = col_wrap ? row_q + dim_t'(1) : row_q;
    col_nxt  = col_wrap ? '0 : col_q + dim_t'(1);
    row      = LOOKAHEAD ? row_nxt : row_q;
    col      = LOOKAHEAD ? col_nxt : col_q;
    last     = (row == m - dim_t'(1)) && (col == n - dim_t'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv) begin
      row_q <= row_nxt;
      col_q <= col_nxt;
    end
  end
endmodule

// File: rtl/mpu_load_store.sv
// Matrix register file with streaming load/store channels, 1 element/cycle each; store data is registered (latency 1).
// Loads stall via ld_data_ready, stores hold st_data/st_valid while st_data_ready=0; same-register load/store interlocked.
module mpu_load_store
  import mpu_load_store_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  mpu_load_store_if.slave bus
);
  load_state_t  ld_state;
  store_state_t st_state;
  raddr_t       ld_addr_q, st_addr_q;
  mpu_dims_t    ld_dims_q, st_dims_q;
  mpu_dims_t    dims [MATRIX_REGISTERS];
  elem_t        mem  [MATRIX_REGISTERS][M][N];

  dim_t ld_row, ld_col, st_row, st_col;
  logic ld_last, st_last_nxt;
  logic ld_busy, st_busy, ld_accept, st_accept, ld_adv, st_adv;

  assign ld_busy = (ld_state == LOAD_MATRIX);
  assign st_busy = (st_state == STORE_MATRIX);

  // Never start writing a register that is still streaming out, and never read one that is half written.
  assign bus.ld_ready      = !ld_busy && !(st_busy && (bus.ld_addr == st_addr_q));
  assign bus.st_ready      = !st_busy && !(ld_busy && (bus.st_addr == ld_addr_q));
  assign bus.ld_data_ready = ld_busy;
  assign bus.st_m          = st_dims_q.m;
  assign bus.st_n          = st_dims_q.n;

  assign ld_accept = !ld_busy && bus.ld_req && bus.ld_ready;
  assign st_accept = !st_busy && bus.st_req && bus.st_ready;
  assign ld_adv    = ld_busy && bus.ld_valid;
  assign st_adv    = st_busy && bus.st_data_ready && !bus.st_last;

  mpu_load_store_elem_counter #(.LOOKAHEAD(1'b0)) u_ld_cnt (
    .clk(clk), .reset_n(reset_n), .clr(ld_accept), .adv(ld_adv),
    .m(ld_dims_q.m), .n(ld_dims_q.n), .row(ld_row), .col(ld_col), .last(ld_last)
  );

  mpu_load_store_elem_counter #(.LOOKAHEAD(1'b1)) u_st_cnt (
    .clk(clk), .reset_n(reset_n), .clr(st_accept), .adv(st_adv),
    .m(st_dims_q.m), .n(st_dims_q.n), .row(st_row), .col(st_col), .last(st_last_nxt)
  );

  always_ff @(posedge clk) begin
    if (ld_adv) mem[ld_addr_q][ld_row][ld_col] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_state     <= LOAD_IDLE;
      ld_addr_q    <= '0;
      ld_dims_q    <= '0;
      bus.ld_done  <= 1'b0;
      bus.ld_error <= 1'b0;
      for (int i = 0; i < MATRIX_REGISTERS; i++) dims[i] <= '0;
    end else begin
      bus.ld_done  <= 1'b0;
      bus.ld_error <= 1'b0;
      case (ld_state)
        LOAD_IDLE: begin
          if (ld_accept) begin
            if (dims_legal(bus.ld_m, bus.ld_n)) begin
              ld_state  <= LOAD_MATRIX;
              ld_addr_q <= bus.ld_addr;
              ld_dims_q <= '{m: bus.ld_m, n: bus.ld_n};
            end else begin
              bus.ld_error <= 1'b1;
            end
          end
        end
        LOAD_MATRIX: begin
          // Dims publish only on completion, so an aborted load leaves the register unreadable.
          if (bus.ld_valid && ld_last) begin
            dims[ld_addr_q] <= ld_dims_q;
            bus.ld_done     <= 1'b1;
            ld_state        <= LOAD_IDLE;
          end
        end
        default: ld_state <= LOAD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_state     <= STORE_IDLE;
      st_addr_q    <= '0;
      st_dims_q    <= '0;
      bus.st_valid <= 1'b0;
      bus.st_data  <= '0;
      bus.st_last  <= 1'b0;
      bus.st_error <= 1'b0;
    end else begin
      bus.st_error <= 1'b0;
      case (st_state)
        STORE_IDLE: begin
          if (st_accept) begin
            if (dims[bus.st_addr].m == '0) begin
              bus.st_error <= 1'b1;
            end else begin
              st_state     <= STORE_MATRIX;
              st_addr_q    <= bus.st_addr;
              st_dims_q    <= dims[bus.st_addr];
              bus.st_valid <= 1'b1;
              bus.st_data  <= mem[bus.st_addr][0][0];
              bus.st_last  <= (dims[bus.st_addr].m == dim_t'(1)) && (dims[bus.st_addr].n == dim_t'(1));
            end
          end
        end
        STORE_MATRIX: begin
          if (bus.st_data_ready) begin
            if (bus.st_last) begin
              bus.st_valid <= 1'b0;
              bus.st_last  <= 1'b0;
              st_state     <= STORE_IDLE;
            end else begin
              bus.st_data <= mem[st_addr_q][st_row][st_col];
              bus.st_last <= st_last_nxt;
            end
          end
        end
        default: st_state <= STORE_IDLE;
      endcase
    end
  end
endmodule
